// File: rtl/seq_alu_mc_if.sv
// Operand/opcode request and registered result bundle for the sequential ALU.
interface seq_alu_mc_if #(
    parameter int M = 7
);
    logic         start;
    logic [2:0]   OpCode;
    logic [M-1:0] A;
    logic [M-1:0] B;
    logic         busy;
    logic         done;
    logic [M-1:0] Result;
    logic [M-1:0] ResultHi;
    logic [4:0]   Flags;

    modport master (
        output start, OpCode, A, B,
        input  busy, done, Result, ResultHi, Flags
    );

    modport slave (
        input  start, OpCode, A, B,
        output busy, done, Result, ResultHi, Flags
    );
endinterface

// File: rtl/seq_alu_mc.sv
// Registered multi-cycle ALU: single-cycle ADD/SUB/OR/AND/XOR plus an
// iterative shift-add unsigned multiplier, with start/busy/done handshake.
module seq_alu_mc #(
    parameter int M = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_alu_mc_if.slave  bus
);
    localparam int CW = (M > 2) ? $clog2(M) : 1;
    localparam int W2 = 2 * M;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [M-1:0]    mcand_q, mcand_d;
    logic [M-1:0]    mplier_q, mplier_d;
    logic [W2-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [M-1:0]    result_q, result_d;
    logic [M-1:0]    result_hi_q, result_hi_d;
    logic [4:0]      flags_q, flags_d;

    logic [M:0]      sum;
    logic [M-1:0]    alu_res;
    logic            alu_c, alu_v;
    logic [4:0]      alu_flags;

    logic [M:0]      mul_sum;
    logic [W2-1:0]   mul_next;
    logic [M-1:0]    mul_hi, mul_lo;
    logic            mul_ovf;
    logic [4:0]      mul_flags;

    // Single-cycle operations work straight from the live inputs.
    always_comb begin
        sum     = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (bus.OpCode)
            OP_ADD: begin
                sum     = {1'b0, bus.A} + {1'b0, bus.B};
                alu_res = sum[M-1:0];
                alu_c   = sum[M];
                alu_v   = (bus.A[M-1] == bus.B[M-1]) && (sum[M-1] != bus.A[M-1]);
            end
            OP_SUB: begin
                sum     = {1'b0, bus.A} + {1'b0, ~bus.B} + {{M{1'b0}}, 1'b1};
                alu_res = sum[M-1:0];
                alu_c   = sum[M];
                alu_v   = (bus.A[M-1] != bus.B[M-1]) && (sum[M-1] != bus.A[M-1]);
            end
            OP_OR:   alu_res = bus.A | bus.B;
            OP_AND:  alu_res = bus.A & bus.B;
            OP_XOR:  alu_res = bus.A ^ bus.B;
            default: alu_res = '0;
        endcase
        alu_flags = {alu_res[M-1], ~|alu_res, alu_c, alu_v, ^alu_res};
    end

    // One shift-add step: add multiplicand into the high half, then shift the
    // whole (2M+1)-bit value right so the next multiplier bit lines up.
    always_comb begin
        mul_sum   = {1'b0, acc_q[W2-1:M]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        mul_next  = W2'({mul_sum, acc_q[M-1:0]} >> 1);
        mul_hi    = mul_next[W2-1:M];
        mul_lo    = mul_next[M-1:0];
        mul_ovf   = |mul_hi;
        mul_flags = {mul_hi[M-1], ~|mul_next, mul_ovf, mul_ovf, ^mul_lo};
    end

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        flags_d     = flags_q;
        case (state_q)
            S_MUL: begin
                acc_d    = mul_next;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(M - 1)) begin
                    result_d    = mul_lo;
                    result_hi_d = mul_hi;
                    flags_d     = mul_flags;
                    state_d     = S_DONE;
                end
            end
            default: begin
                // DONE accepts a new start exactly like IDLE for gapless issue.
                state_d = S_IDLE;
                if (bus.start) begin
                    if (bus.OpCode == OP_MUL) begin
                        mcand_d  = bus.A;
                        mplier_d = bus.B;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = S_MUL;
                    end else begin
                        result_d    = alu_res;
                        result_hi_d = '0;
                        flags_d     = alu_flags;
                        state_d     = S_DONE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            flags_q     <= flags_d;
        end
    end

    assign bus.busy     = (state_q == S_MUL);
    assign bus.done     = (state_q == S_DONE);
    assign bus.Result   = result_q;
    assign bus.ResultHi = result_hi_q;
    assign bus.Flags    = flags_q;
endmodule

// File: tb/tb_seq_alu_mc.sv
// Scoreboard bench for seq_alu_mc: expected results queued at issue, popped on done.
module tb_seq_alu_mc;
    localparam int M    = 7;
    localparam int W    = 1 << M;
    localparam int HALF = 1 << (M - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b100;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    seq_alu_mc_if #(.M(M)) bus();

    seq_alu_mc #(.M(M)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [M-1:0] res;
        logic [M-1:0] hi;
        logic [4:0]   flags;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    function automatic exp_t model(input logic [2:0] op, input logic [M-1:0] a,
                                   input logic [M-1:0] b);
        int   ua, ub, sa, sb, full, s;
        exp_t e;
        logic c, v, n;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= HALF) ? ua - W : ua;
        sb = (ub >= HALF) ? ub - W : ub;
        e.res = '0;
        e.hi  = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'b000: begin
                full = ua + ub; e.res = M'(full % W); c = (full >= W);
                s = sa + sb; v = (s >= HALF) || (s < -HALF);
            end
            3'b001: begin
                full = ua - ub + W; e.res = M'(full % W); c = (ua >= ub);
                s = sa - sb; v = (s >= HALF) || (s < -HALF);
            end
            3'b010: e.res = a | b;
            3'b011: e.res = a & b;
            3'b101: e.res = a ^ b;
            3'b100: begin
                full = ua * ub; e.res = M'(full % W); e.hi = M'(full / W);
                c = (e.hi != 0); v = c;
            end
            default: e.res = '0;
        endcase
        n = (op == 3'b100) ? e.hi[M-1] : e.res[M-1];
        e.flags = {n, (e.res == 0) && (e.hi == 0), c, v, ^e.res};
        return e;
    endfunction

    // Issue one start pulse; returns at the falling edge after the sampling edge.
    task automatic send(input logic [2:0] op, input logic [M-1:0] a, input logic [M-1:0] b);
        @(negedge clk);
        bus.start = 1'b1; bus.OpCode = op; bus.A = a; bus.B = b;
        exp_q.push_back(model(op, a, b));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_n);
        lat = 0;
        busy_n = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) busy_n++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.Result, bus.ResultHi, bus.Flags} !== '0)
            $display("FAIL reset_state: got busy=%b done=%b R=%0d H=%0d F=%b expected all 0",
                     bus.busy, bus.done, bus.Result, bus.ResultHi, bus.Flags);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        int   lat, bn;
        exp_t e;
        send(OP_ADD, 7'd100, 7'd50);
        wait_done(lat, bn);
        checks++;
        if (bus.done !== 1'b1 || lat != 0 || bus.busy !== 1'b0)
            $display("FAIL add_latency: got done=%b lat=%0d busy=%b expected done=1 lat=0 busy=0",
                     bus.done, lat, bus.busy);
        else passed++;
        e = exp_q.pop_front();
        checks++;
        if ({bus.Result, bus.ResultHi, bus.Flags} !== e)
            $display("FAIL add_result: got %0d/%0d/%b expected %0d/%0d/%b",
                     bus.Result, bus.ResultHi, bus.Flags, e.res, e.hi, e.flags);
        else passed++;
        checks++;
        if ({bus.Result, bus.ResultHi, bus.Flags} !== {7'd22, 7'd0, 5'b00101})
            $display("FAIL add_const: got %0d/%0d/%b expected 22/0/00101",
                     bus.Result, bus.ResultHi, bus.Flags);
        else passed++;
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) $display("FAIL add_done_pulse: got done=%b expected 0", bus.done);
        else passed++;
    endtask

    task automatic test_sub;
        int   lat, bn;
        exp_t e;
        logic [M-1:0] va[3] = '{7'b0001101, 7'd77, 7'd64};
        logic [M-1:0] vb[3] = '{7'b1100000, 7'd77, 7'd1};
        for (int i = 0; i < 3; i++) begin
            send(OP_SUB, va[i], vb[i]);
            wait_done(lat, bn);
            e = exp_q.pop_front();
            checks++;
            if (bus.done !== 1'b1 || {bus.Result, bus.ResultHi, bus.Flags} !== e)
                $display("FAIL sub_result[%0d]: got done=%b %0d/%0d/%b expected %0d/%0d/%b", i,
                         bus.done, bus.Result, bus.ResultHi, bus.Flags, e.res, e.hi, e.flags);
            else passed++;
            if (i == 0) begin
                checks++;
                if ({bus.Result, bus.Flags} !== {7'd45, 5'b00000})
                    $display("FAIL sub_const: got %0d/%b expected 45/00000", bus.Result, bus.Flags);
                else passed++;
            end
        end
    endtask

    task automatic test_mul;
        int   lat, bn;
        exp_t e;
        send(OP_MUL, 7'd100, 7'd50);
        lat = 0;
        bn = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) bn++;
            bus.A = M'($urandom);
            bus.B = M'($urandom);
            bus.OpCode = 3'($urandom);
            @(negedge clk);
            lat++;
        end
        checks++;
        if (bus.done !== 1'b1 || lat != M || bn != M || bus.busy !== 1'b0)
            $display("FAIL mul_timing: got done=%b lat=%0d busy_cycles=%0d expected done=1 lat=%0d busy_cycles=%0d",
                     bus.done, lat, bn, M, M);
        else passed++;
        e = exp_q.pop_front();
        checks++;
        if ({bus.Result, bus.ResultHi, bus.Flags} !== e)
            $display("FAIL mul_result: got %0d/%0d/%b expected %0d/%0d/%b",
                     bus.Result, bus.ResultHi, bus.Flags, e.res, e.hi, e.flags);
        else passed++;
        checks++;
        if ({bus.Result, bus.ResultHi, bus.Flags} !== {7'd8, 7'd39, 5'b00111})
            $display("FAIL mul_const: got %0d/%0d/%b expected 8/39/00111",
                     bus.Result, bus.ResultHi, bus.Flags);
        else passed++;
        send(OP_MUL, 7'd0, 7'd85);
        wait_done(lat, bn);
        e = exp_q.pop_front();
        checks++;
        if (bus.done !== 1'b1 || {bus.Result, bus.ResultHi, bus.Flags} !== e)
            $display("FAIL mul_zero: got done=%b %0d/%0d/%b expected %0d/%0d/%b", bus.done,
                     bus.Result, bus.ResultHi, bus.Flags, e.res, e.hi, e.flags);
        else passed++;
        send(OP_MUL, 7'd127, 7'd127);
        wait_done(lat, bn);
        e = exp_q.pop_front();
        checks++;
        if (bus.done !== 1'b1 || {bus.Result, bus.ResultHi, bus.Flags} !== e)
            $display("FAIL mul_max: got done=%b %0d/%0d/%b expected %0d/%0d/%b", bus.done,
                     bus.Result, bus.ResultHi, bus.Flags, e.res, e.hi, e.flags);
        else passed++;
    endtask

    task automatic test_reset_abort;
        int   lat, bn, dones;
        exp_t e;
        send(OP_MUL, 7'd100, 7'd50);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.Result, bus.ResultHi, bus.Flags} !== '0)
            $display("FAIL abort_clear: got busy=%b done=%b R=%0d H=%0d F=%b expected all 0",
                     bus.busy, bus.done, bus.Result, bus.ResultHi, bus.Flags);
        else passed++;
        exp_q.delete();
        dones = 0;
        for (int i = 0; i < M + 3; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
            if (i == 2) rst_n = 1'b1;
        end
        checks++;
        if (dones != 0) $display("FAIL abort_no_done: got %0d done pulses expected 0", dones);
        else passed++;
        send(OP_ADD, 7'd3, 7'd4);
        wait_done(lat, bn);
        e = exp_q.pop_front();
        checks++;
        if (bus.done !== 1'b1 || lat != 0 || {bus.Result, bus.ResultHi, bus.Flags} !== e)
            $display("FAIL abort_recover: got done=%b lat=%0d %0d/%0d/%b expected done=1 lat=0 %0d/%0d/%b",
                     bus.done, lat, bus.Result, bus.ResultHi, bus.Flags, e.res, e.hi, e.flags);
        else passed++;
    endtask

    task automatic test_busy_ignore;
        int   lat, bn, dones;
        exp_t e;
        send(OP_MUL, 7'd9, 7'd11);
        dones = 0;
        for (int i = 0; i < M + 5; i++) begin
            if (bus.done) begin
                dones++;
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL ignore_extra_done: got done at step %0d expected none", i);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.Result, bus.ResultHi, bus.Flags} !== e)
                        $display("FAIL ignore_result: got %0d/%0d/%b expected %0d/%0d/%b",
                                 bus.Result, bus.ResultHi, bus.Flags, e.res, e.hi, e.flags);
                    else passed++;
                end
            end
            bus.start = (i == 2);
            bus.OpCode = OP_ADD; bus.A = 7'd1; bus.B = 7'd1;
            @(negedge clk);
        end
        bus.start = 1'b0;
        checks++;
        if (dones != 1) $display("FAIL ignore_done_count: got %0d done pulses expected 1", dones);
        else passed++;
        for (int k = 0; k < 2; k++) begin
            send(k == 0 ? 3'b110 : 3'b111, 7'd55, 7'd33);
            wait_done(lat, bn);
            e = exp_q.pop_front();
            checks++;
            if (bus.done !== 1'b1 || {bus.Result, bus.ResultHi, bus.Flags} !== e ||
                bus.Flags !== 5'b01000)
                $display("FAIL reserved_op[%0d]: got done=%b %0d/%0d/%b expected 0/0/01000", k,
                         bus.done, bus.Result, bus.ResultHi, bus.Flags);
            else passed++;
        end
    endtask

    task automatic test_back_to_back;
        logic [M-1:0] a, b;
        exp_t         e;
        a = 7'd120;
        b = 7'd10;
        @(negedge clk);
        bus.start = 1'b1; bus.OpCode = OP_ADD; bus.A = a; bus.B = b;
        exp_q.push_back(model(OP_ADD, a, b));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (bus.done !== 1'b1 || {bus.Result, bus.ResultHi, bus.Flags} !== e)
                $display("FAIL b2b[%0d]: got done=%b %0d/%0d/%b expected done=1 %0d/%0d/%b", i,
                         bus.done, bus.Result, bus.ResultHi, bus.Flags, e.res, e.hi, e.flags);
            else passed++;
            a = a + 1'b1;
            if (i == 10) b = 7'd60;
            if (i < 19) begin
                bus.A = a; bus.B = b;
                exp_q.push_back(model(OP_ADD, a, b));
            end else begin
                bus.start = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) $display("FAIL b2b_stop: got done=%b expected 0", bus.done);
        else passed++;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.OpCode = '0;
        bus.A = '0;
        bus.B = '0;
        test_reset;
        test_add;
        test_sub;
        test_mul;
        test_reset_abort;
        test_busy_ignore;
        test_back_to_back;
        checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
